// File: rtl/ram_rw_arbiter.sv
// Purpose: round-robin owner of the single RAM_RW transfer port for recorder (0), player (1) and denoise engine (2).
// Latency: grant, owner and req_valid appear one clk after a request is seen in IDLE; every output is registered.
// Backpressure: req_valid is held until req_ready (or timeout), release waits for busy low, then a GAP_CYCLES stop guard.
module ram_rw_arbiter #(
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       daclrck,
   input  logic [2:0] rq_req,
   input  logic [2:0] rq_type,
   input  logic [2:0] rq_target,
   input  logic [2:0] rq_stop,
   output logic [2:0] rq_grant,
   output logic [2:0] rq_done,
   output logic       req_valid,
   output logic       req_type,
   output logic       req_target,
   output logic       stop,
   input  logic       req_ready,
   input  logic       busy,
   output logic [1:0] owner,
   output logic       timeout_err
);

   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, ISSUE, ACTIVE, RELEASE, GAP} state_t;

   state_t        state_q, state_d;
   logic [1:0]    owner_q, owner_d;
   logic [1:0]    last_q, last_d;
   logic [2:0]    grant_q, grant_d;
   logic [2:0]    done_q, done_d;
   logic          valid_q, valid_d;
   logic          type_q, type_d;
   logic          target_q, target_d;
   logic          stop_q, stop_d;
   logic          terr_q, terr_d;
   logic          seen_q, seen_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [TW-1:0] to_q, to_d;

   logic          win_vld;
   logic [1:0]    win;
   logic [1:0]    cand;
   logic          own_req;
   logic          own_stop;

   // State and registered outputs; reset drops everything back to idle with stop asserted.
   always_ff @(posedge clk or posedge daclrck) begin
      if (daclrck) begin
         state_q  <= IDLE;
         owner_q  <= 2'd3;
         last_q   <= 2'd2;
         grant_q  <= 3'b000;
         done_q   <= 3'b000;
         valid_q  <= 1'b0;
         type_q   <= 1'b0;
         target_q <= 1'b0;
         stop_q   <= 1'b1;
         terr_q   <= 1'b0;
         seen_q   <= 1'b0;
         gap_q    <= '0;
         to_q     <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         grant_q  <= grant_d;
         done_q   <= done_d;
         valid_q  <= valid_d;
         type_q   <= type_d;
         target_q <= target_d;
         stop_q   <= stop_d;
         terr_q   <= terr_d;
         seen_q   <= seen_d;
         gap_q    <= gap_d;
         to_q     <= to_d;
      end
   end

   // Next-state logic; outputs are computed for the state being entered so they leave the flops directly.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      grant_d  = grant_q;
      done_d   = 3'b000;
      valid_d  = valid_q;
      type_d   = type_q;
      target_d = target_q;
      stop_d   = stop_q;
      terr_d   = 1'b0;
      seen_d   = seen_q;
      gap_d    = gap_q;
      to_d     = to_q;

      // Round-robin search starting just after the last owner, wrapping 2 -> 0.
      win_vld = 1'b0;
      win     = 2'd0;
      cand    = last_q;
      for (int k = 0; k < 3; k++) begin
         cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
         if (!win_vld && rq_req[cand]) begin
            win_vld = 1'b1;
            win     = cand;
         end
      end

      own_req  = |(rq_req & grant_q);
      own_stop = |(rq_stop & grant_q);

      case (state_q)
         IDLE: begin
            stop_d  = 1'b1;
            valid_d = 1'b0;
            if (win_vld) begin
               state_d  = ISSUE;
               owner_d  = win;
               grant_d  = 3'b001 << win;
               type_d   = rq_type[win];
               target_d = rq_target[win];
               valid_d  = 1'b1;
               stop_d   = 1'b0;
               to_d     = '0;
            end
         end
         ISSUE: begin
            if (req_ready) begin
               state_d = ACTIVE;
               valid_d = 1'b0;
               stop_d  = 1'b0;
               seen_d  = 1'b0;
            end else if (!own_req || to_q == TO_LAST) begin
               // Withdraw or timeout: no done pulse, but the pointer still moves on.
               terr_d  = own_req;
               state_d = GAP;
               valid_d = 1'b0;
               stop_d  = 1'b1;
               grant_d = 3'b000;
               owner_d = 2'd3;
               last_d  = owner_q;
               gap_d   = '0;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         ACTIVE: begin
            if (!own_req || own_stop || (seen_q && !busy)) begin
               state_d = RELEASE;
               stop_d  = 1'b1;
            end else begin
               stop_d = 1'b0;
               if (busy) begin
                  seen_d = 1'b1;
               end
            end
         end
         RELEASE: begin
            stop_d = 1'b1;
            if (!busy) begin
               done_d  = grant_q;
               grant_d = 3'b000;
               owner_d = 2'd3;
               last_d  = owner_q;
               state_d = GAP;
               gap_d   = '0;
            end
         end
         GAP: begin
            stop_d = 1'b1;
            if (gap_q == GAP_LAST) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign rq_grant    = grant_q;
   assign rq_done     = done_q;
   assign req_valid   = valid_q;
   assign req_type    = type_q;
   assign req_target  = target_q;
   assign stop        = stop_q;
   assign owner       = owner_q;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_ram_rw_arbiter.sv
// Bench for ram_rw_arbiter: directed scenarios with literal expectations, then random requesters and RAM_RW.
// A transfer-level model tracks who owns the port and what phase the transfer is in; outputs are compared every cycle.
// Inputs change 2 time units after the rising edge; outputs are sampled on the falling edge.
module tb_ram_rw_arbiter;

   localparam int GAP = 4;
   localparam int TO  = 8;

   logic       clk;
   logic       daclrck;
   logic [2:0] rq_req, rq_type, rq_target, rq_stop;
   logic [2:0] rq_grant, rq_done;
   logic       req_valid, req_type, req_target, stop;
   logic       req_ready, busy;
   logic [1:0] owner;
   logic       timeout_err;

   int vectors     = 0;
   int miscompares = 0;

   // Model: m_own = owning requester (-1 none); m_age = ISSUE cycles elapsed (-1 when not issuing);
   // m_xfer = data transfer running; m_drain = waiting for busy low; m_gap = guard cycles still to run.
   int         m_own   = -1;
   int         m_age   = -1;
   int         m_gap   = 0;
   int         m_last  = 2;
   bit         m_xfer  = 1'b0;
   bit         m_drain = 1'b0;
   bit         m_seen  = 1'b0;
   logic       m_terr  = 1'b0;
   logic       m_type  = 1'b0;
   logic       m_tgt   = 1'b0;
   logic [2:0] m_done  = 3'b000;

   bit ram_auto  = 1'b0;
   bit ram_cut   = 1'b0;
   bit rnd_req   = 1'b0;
   int ready_pct = 100;
   int busy_len  = 5;
   int busy_left = 0;

   int exp_ord [4] = '{0, 1, 2, 0};

   ram_rw_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .daclrck     (daclrck),
      .rq_req      (rq_req),
      .rq_type     (rq_type),
      .rq_target   (rq_target),
      .rq_stop     (rq_stop),
      .rq_grant    (rq_grant),
      .rq_done     (rq_done),
      .req_valid   (req_valid),
      .req_type    (req_type),
      .req_target  (req_target),
      .stop        (stop),
      .req_ready   (req_ready),
      .busy        (busy),
      .owner       (owner),
      .timeout_err (timeout_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic end_owner();
      m_last  = m_own;
      m_own   = -1;
      m_age   = -1;
      m_xfer  = 1'b0;
      m_drain = 1'b0;
      m_gap   = GAP;
   endtask

   task automatic model_step();
      int idx;
      if (daclrck) begin
         m_own = -1; m_age = -1; m_gap = 0; m_last = 2;
         m_xfer = 1'b0; m_drain = 1'b0; m_seen = 1'b0;
         m_terr = 1'b0; m_type = 1'b0; m_tgt = 1'b0; m_done = 3'b000;
         return;
      end
      m_done = 3'b000;
      m_terr = 1'b0;
      if (m_own < 0) begin
         if (m_gap > 0) begin
            m_gap--;
         end else begin
            for (int k = 1; k <= 3; k++) begin
               idx = (m_last + k) % 3;
               if (m_own < 0 && rq_req[idx]) begin
                  m_own  = idx;
                  m_type = rq_type[idx];
                  m_tgt  = rq_target[idx];
                  m_age  = 0;
               end
            end
         end
      end else if (m_age >= 0) begin
         if (req_ready) begin
            m_age  = -1;
            m_xfer = 1'b1;
            m_seen = 1'b0;
         end else if (!rq_req[m_own]) begin
            end_owner();
         end else if (m_age + 1 == TO) begin
            m_terr = 1'b1;
            end_owner();
         end else begin
            m_age++;
         end
      end else if (m_xfer) begin
         if (!rq_req[m_own] || rq_stop[m_own] || (m_seen && !busy)) begin
            m_xfer  = 1'b0;
            m_drain = 1'b1;
         end else if (busy) begin
            m_seen = 1'b1;
         end
      end else if (m_drain && !busy) begin
         m_done[m_own] = 1'b1;
         end_owner();
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge daclrck);
         model_step();
      end
   end

   task automatic compare_model();
      logic [2:0] eg;
      eg = (m_own >= 0) ? (3'b001 << m_own) : 3'b000;
      vectors++;
      chk("grant", 32'(rq_grant), 32'(eg));
      chk("owner", 32'(owner), (m_own >= 0) ? 32'(m_own) : 32'd3);
      chk("req_valid", 32'(req_valid), 32'(m_age >= 0));
      chk("stop", 32'(stop), 32'(!(m_age >= 0 || m_xfer)));
      chk("req_type", 32'(req_type), 32'(m_type));
      chk("req_target", 32'(req_target), 32'(m_tgt));
      chk("done", 32'(rq_done), 32'(m_done));
      chk("timeout_err", 32'(timeout_err), 32'(m_terr));
   endtask

   task automatic ram_step();
      if (req_ready) begin
         req_ready = 1'b0;
         busy_left = busy_len;
      end else if (req_valid && int'($urandom_range(99)) < ready_pct) begin
         req_ready = 1'b1;
      end
      if (ram_cut && stop && busy_left > 2) busy_left = int'($urandom_range(2));
      busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
   endtask

   task automatic req_step();
      int p;
      for (int i = 0; i < 3; i++) begin
         p = int'($urandom_range(99));
         if (rq_done[i]) begin
            rq_req[i]  = 1'b0;
            rq_stop[i] = 1'b0;
         end else if (!rq_req[i]) begin
            if (p < 8) begin
               rq_req[i]    = 1'b1;
               rq_stop[i]   = 1'b0;
               rq_type[i]   = 1'($urandom_range(1));
               rq_target[i] = 1'($urandom_range(1));
            end
         end else if (rq_grant[i]) begin
            rq_type[i]   = 1'($urandom_range(1));
            rq_target[i] = 1'($urandom_range(1));
            if (req_valid && p < 4) begin
               rq_req[i]  = 1'b0;
               rq_stop[i] = 1'b0;
            end else if (!req_valid && !stop) begin
               if (p < 3) begin
                  rq_req[i]  = 1'b0;
                  rq_stop[i] = 1'b0;
               end else if (p < 7) begin
                  rq_stop[i] = 1'b1;
               end
            end
         end else if (p < 1) begin
            rq_req[i]  = 1'b0;
            rq_stop[i] = 1'b0;
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
      if (rnd_req) req_step();
      if (ram_auto) ram_step();
      @(negedge clk);
      compare_model();
   endtask

   task automatic flush(int n);
      repeat (n) cyc();
   endtask

   initial begin
      int         ord[$];
      int         gcnt[$];
      logic [2:0] pg;
      int         run, nv, w;
      bit         hit;

      daclrck = 1'b1;
      rq_req = 3'b000; rq_type = 3'b000; rq_target = 3'b000; rq_stop = 3'b000;
      req_ready = 1'b0; busy = 1'b0;

      // Reset values.
      flush(3);
      chk("rst_stop", 32'(stop), 1);
      chk("rst_owner", 32'(owner), 3);
      chk("rst_grant", 32'(rq_grant), 0);
      chk("rst_valid", 32'(req_valid), 0);
      daclrck = 1'b0;

      // First request: write Rx from requester 0, type toggled during ISSUE.
      rq_req = 3'b001; rq_type = 3'b001; rq_target = 3'b000;
      cyc();
      chk("t1_valid", 32'(req_valid), 1);
      chk("t1_type", 32'(req_type), 1);
      chk("t1_target", 32'(req_target), 0);
      chk("t1_grant", 32'(rq_grant), 32'(3'b001));
      chk("t1_owner", 32'(owner), 0);
      rq_type = 3'b000;
      cyc();
      chk("t1_type_held", 32'(req_type), 1);
      chk("t1_valid_held", 32'(req_valid), 1);
      req_ready = 1'b1;
      cyc();
      chk("t1_valid_drop", 32'(req_valid), 0);
      chk("t1_stop_active", 32'(stop), 0);
      req_ready = 1'b0; rq_req = 3'b000;
      cyc();
      chk("t1_stop_release", 32'(stop), 1);
      cyc();
      chk("t1_done", 32'(rq_done), 32'(3'b001));
      chk("t1_grant_clear", 32'(rq_grant), 0);
      flush(8);

      // Three continuous requesters, self-terminating 5-cycle busy bursts.
      daclrck = 1'b1;
      cyc();
      daclrck = 1'b0;
      rq_req = 3'b111; rq_type = 3'b101; rq_target = 3'b011;
      ram_auto = 1'b1; ram_cut = 1'b0; ready_pct = 100; busy_len = 5;
      pg = 3'b000; run = -1;
      for (int c = 0; c < 300 && ord.size() < 4; c++) begin
         cyc();
         if (rq_grant != 3'b000 && pg == 3'b000) ord.push_back(int'(owner));
         pg = rq_grant;
         if (run >= 0) begin
            if (stop) run++;
            else begin
               gcnt.push_back(run);
               run = -1;
            end
         end
         if (rq_done != 3'b000) run = 0;
      end
      chk("t2_grant_count", 32'(ord.size()), 4);
      for (int i = 0; i < ord.size() && i < 4; i++) chk("t2_grant_order", 32'(ord[i]), 32'(exp_ord[i]));
      chk("t2_gap_count", 32'(gcnt.size()), 3);
      foreach (gcnt[i]) chk("t2_gap_len", 32'(gcnt[i]), GAP);
      rq_req = 3'b000;
      flush(20);

      // Owner 1 stops while busy stays high for 10 more cycles.
      ram_auto = 1'b0; req_ready = 1'b0; busy = 1'b0;
      rq_req = 3'b010;
      cyc();
      chk("t3_grant", 32'(rq_grant), 32'(3'b010));
      req_ready = 1'b1;
      cyc();
      req_ready = 1'b0; busy = 1'b1;
      cyc();
      cyc();
      rq_stop = 3'b010;
      cyc();
      chk("t3_stop_now", 32'(stop), 1);
      for (int c = 0; c < 9; c++) begin
         cyc();
         chk("t3_no_early_done", 32'(rq_done), 0);
      end
      busy = 1'b0;
      cyc();
      chk("t3_done", 32'(rq_done), 32'(3'b010));
      rq_req = 3'b000; rq_stop = 3'b000;
      flush(8);

      // req_ready never comes: timeout on requester 2, then requester 0 after the gap.
      nv = 0; hit = 1'b0;
      rq_req = 3'b101;
      cyc();
      chk("t4_first_grant", 32'(rq_grant), 32'(3'b100));
      if (req_valid) nv++;
      for (int c = 0; c < 20 && !hit; c++) begin
         cyc();
         if (rq_done != 3'b000) chk("t4_no_done", 32'(rq_done), 0);
         if (timeout_err) begin
            hit = 1'b1;
            chk("t4_valid_low", 32'(req_valid), 0);
            chk("t4_grant_low", 32'(rq_grant), 0);
            chk("t4_stop_high", 32'(stop), 1);
         end else if (req_valid) begin
            nv++;
         end
      end
      chk("t4_timeout_seen", 32'(hit), 1);
      chk("t4_issue_cycles", 32'(nv), TO);
      w = 0;
      for (int c = 0; c < 12 && rq_grant == 3'b000; c++) begin
         cyc();
         w++;
      end
      chk("t4_next_grant", 32'(rq_grant), 32'(3'b001));
      chk("t4_gap_to_grant", 32'(w), GAP + 1);
      rq_req = 3'b000;
      cyc();
      chk("t4_withdraw_valid", 32'(req_valid), 0);
      chk("t4_withdraw_grant", 32'(rq_grant), 0);
      flush(8);

      // Asynchronous reset in the middle of an ACTIVE transfer.
      rq_req = 3'b100;
      cyc();
      req_ready = 1'b1;
      cyc();
      req_ready = 1'b0; busy = 1'b1;
      cyc();
      chk("t5_active", 32'(stop), 0);
      rq_req = 3'b111;
      #2 daclrck = 1'b1;
      #1;
      chk("t5_rst_stop", 32'(stop), 1);
      chk("t5_rst_valid", 32'(req_valid), 0);
      chk("t5_rst_grant", 32'(rq_grant), 0);
      chk("t5_rst_owner", 32'(owner), 3);
      chk("t5_rst_done", 32'(rq_done), 0);
      #1 daclrck = 1'b0;
      cyc();
      chk("t5_first_winner", 32'(rq_grant), 32'(3'b001));
      busy = 1'b0; rq_req = 3'b000;
      flush(8);

      // Random requesters against a random RAM_RW.
      ram_auto = 1'b1; ram_cut = 1'b1; ready_pct = 30; rnd_req = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         busy_len = int'($urandom_range(12));
         cyc();
      end
      rnd_req = 1'b0; rq_req = 3'b000; rq_stop = 3'b000;
      flush(40);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
